// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad responder: FSM state encoding,
// matrix dimensions and key-code field extraction.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef enum logic [2:0] {
    KP_IDLE,
    KP_PRESS,
    KP_HOLD,
    KP_RELEASE,
    KP_GAP
  } kp_state_t;

  function automatic logic [1:0] key_row(input logic [3:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] code);
    return code[1:0];
  endfunction

endpackage

// File: rtl/kp_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) supplying contact bounce noise.
// Compiled only when KEYPAD_BOUNCE_EN is defined.
`ifdef KEYPAD_BOUNCE_EN
module kp_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] state
);

  localparam logic [7:0] SEED = 8'hA5;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
    end
  end

endmodule
`endif

// File: rtl/keypad_emulator.sv
// Matrix-keypad responder: plays each submitted key through press/hold/release/gap
// on the active-low row lines. Define KEYPAD_BOUNCE_EN for LFSR contact bounce.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 2000,
  parameter int unsigned BOUNCE_CYCLES = 64,
  parameter int unsigned GAP_CYCLES    = 500,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [3:0]         key_code,
  output logic               key_ready,
  input  logic [KP_COLS-1:0] col_in,
  output logic [KP_ROWS-1:0] row_out,
  output logic               busy,
  output logic               key_done
);

  localparam logic [CNT_W-1:0] HOLD_LEN   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] BOUNCE_LEN = CNT_W'(BOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LEN    = CNT_W'(GAP_CYCLES);

  kp_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, phase_len;
  logic [3:0]         key_q, key_d;
  logic               done_d;
  logic               phase_last;
  logic               contact;
  logic [KP_ROWS-1:0] row_d;

  assign key_ready = (state_q == KP_IDLE);
  assign busy      = (state_q != KP_IDLE);

  // A zero-length phase still occupies one cycle, so it counts as "last" at once.
  always_comb begin
    phase_len = '0;
    unique case (state_q)
      KP_PRESS, KP_RELEASE: phase_len = BOUNCE_LEN;
      KP_HOLD:              phase_len = HOLD_LEN;
      KP_GAP:               phase_len = GAP_LEN;
      default:              phase_len = '0;
    endcase
  end

  assign phase_last = (phase_len == '0) || (cnt_q == phase_len - CNT_W'(1));

`ifdef KEYPAD_BOUNCE_EN
  logic [7:0] lfsr;

  kp_lfsr8 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .state (lfsr)
  );

  // Bounce settles on the final cycle so each window ends in its clean level.
  always_comb begin
    contact = 1'b0;
    unique case (state_q)
      KP_PRESS:   contact = phase_last ? 1'b1 : lfsr[0];
      KP_HOLD:    contact = 1'b1;
      KP_RELEASE: contact = phase_last ? 1'b0 : lfsr[0];
      default:    contact = 1'b0;
    endcase
  end
`else
  assign contact = (state_q == KP_PRESS) || (state_q == KP_HOLD);
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    done_d  = 1'b0;
    if (state_q == KP_IDLE) begin
      if (key_valid) begin
        state_d = KP_PRESS;
        cnt_d   = '0;
        key_d   = key_code;
      end
    end else if (phase_last) begin
      cnt_d = '0;
      unique case (state_q)
        KP_PRESS:   state_d = KP_HOLD;
        KP_HOLD:    state_d = KP_RELEASE;
        KP_RELEASE: state_d = KP_GAP;
        KP_GAP: begin
          state_d = KP_IDLE;
          done_d  = 1'b1;
        end
        default:    state_d = KP_IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    row_d = '1;
    if (contact && !col_in[key_col(key_q)]) begin
      row_d[key_row(key_q)] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the reset here is synchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= KP_IDLE;
      cnt_q    <= '0;
      key_q    <= '0;
      key_done <= 1'b0;
      row_out  <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      key_done <= done_d;
      row_out  <= row_d;
    end
  end

endmodule
